version_streamer: RTL and testbench



---
 rtl/version_pkg.sv | 15 +
 rtl/version_stream_pkg.sv | 57 +++++
 rtl/version_beacon_timer.sv | 30 +++
 rtl/version_streamer.sv | 113 +++++++++++
 tb/tb_version_streamer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/version_pkg.sv
// Build-identification constants: version numbers and BCD build date/time.
package version_pkg;

  localparam logic [7:0]  VERSION_MAJOR = 8'h00;
  localparam logic [7:0]  VERSION_MINOR = 8'h00;
  localparam logic [7:0]  VERSION_PATCH = 8'h00;
  localparam logic [7:0]  VERSION_BUILD = 8'h48;
  localparam logic [15:0] BUILD_YEAR    = 16'h2026;
  localparam logic [7:0]  BUILD_MONTH   = 8'h01;
  localparam logic [7:0]  BUILD_DAY     = 8'h07;
  localparam logic [7:0]  BUILD_HOUR    = 8'h12;
  localparam logic [7:0]  BUILD_MINUTE  = 8'h23;
  localparam logic [7:0]  BUILD_SECOND  = 8'h05;

endpackage

// File: rtl/version_stream_pkg.sv
// Packet layout for version_streamer. VERSION_STREAM_CKSUM_EN appends a checksum byte
// computed at elaboration so that LEN + payload + CKSUM sums to zero mod 256.
package version_stream_pkg;
  import version_pkg::*;

  localparam logic [7:0]  C_SOF_DEFAULT = 8'hA5;
  localparam int unsigned C_PAYLOAD_LEN = 11;
`ifdef VERSION_STREAM_CKSUM_EN
  localparam int unsigned C_PKT_BYTES   = 14;
`else
  localparam int unsigned C_PKT_BYTES   = 13;
`endif

  typedef enum logic [0:0] {ST_IDLE, ST_SEND} stream_state_e;

  function automatic logic [7:0] payload_byte(int unsigned i);
    case (i)
      0:       return VERSION_MAJOR;
      1:       return VERSION_MINOR;
      2:       return VERSION_PATCH;
      3:       return VERSION_BUILD;
      4:       return BUILD_YEAR[15:8];
      5:       return BUILD_YEAR[7:0];
      6:       return BUILD_MONTH;
      7:       return BUILD_DAY;
      8:       return BUILD_HOUR;
      9:       return BUILD_MINUTE;
      10:      return BUILD_SECOND;
      default: return 8'h00;
    endcase
  endfunction

`ifdef VERSION_STREAM_CKSUM_EN
  function automatic logic [7:0] calc_cksum();
    logic [7:0] sum;
    sum = 8'(C_PAYLOAD_LEN);
    for (int unsigned i = 0; i < C_PAYLOAD_LEN; i++) begin
      sum = sum + payload_byte(i);
    end
    return 8'h00 - sum;
  endfunction

  localparam logic [7:0] C_CKSUM = calc_cksum();
`endif

  // Byte i of the packet, 0 = SOF; out-of-range indices read as zero.
  function automatic logic [7:0] pkt_byte(int unsigned i, logic [7:0] sof);
    if (i == 0) return sof;
    if (i == 1) return 8'(C_PAYLOAD_LEN);
    if (i < 2 + C_PAYLOAD_LEN) return payload_byte(i - 2);
`ifdef VERSION_STREAM_CKSUM_EN
    if (i == 2 + C_PAYLOAD_LEN) return C_CKSUM;
`endif
    return 8'h00;
  endfunction

endpackage

// File: rtl/version_beacon_timer.sv
// Free-running beacon counter: pulses expire for one cycle every BEACON_CYCLES clocks.
// Tied off (no counter) when BEACON_CYCLES is 0.
module version_beacon_timer #(
  parameter int unsigned BEACON_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  output logic expire
);

  if (BEACON_CYCLES == 0) begin : g_off
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign expire = 1'b0;
  end else begin : g_on
    logic [31:0] cnt_q, cnt_d;

    assign expire = (cnt_q == 32'(BEACON_CYCLES - 1));
    assign cnt_d  = expire ? 32'd0 : cnt_q + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= 32'd0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/version_streamer.sv
// Streams the build-identification packet on a DATA_W-wide valid/ready bus, on req or beacon.
// Define VERSION_STREAM_CKSUM_EN to append a checksum byte (14-byte packet).
module version_streamer
  import version_stream_pkg::*;
#(
  parameter int unsigned DATA_W        = 8,
  parameter logic [7:0]  SOF_BYTE      = C_SOF_DEFAULT,
  parameter int unsigned BEACON_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  output logic [DATA_W-1:0]   m_data,
  output logic [DATA_W/8-1:0] m_keep,
  output logic                m_valid,
  output logic                m_last,
  input  logic                m_ready,
  output logic                busy,
  output logic [15:0]         pkt_cnt
);

  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_width
    $error("version_streamer: DATA_W must be 8, 16 or 32");
  end

  localparam int unsigned Lanes = DATA_W / 8;
  localparam int unsigned Beats = (C_PKT_BYTES + Lanes - 1) / Lanes;

  stream_state_e state_q, state_d;
  logic          pending_q, pending_d;
  logic [3:0]    beat_q, beat_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;
  logic          beacon_expire;
  logic          last_beat;
  logic          hs;

  version_beacon_timer #(
    .BEACON_CYCLES(BEACON_CYCLES)
  ) u_beacon (
    .clk    (clk),
    .rst_n  (rst_n),
    .expire (beacon_expire)
  );

  assign last_beat = (beat_q == 4'(Beats - 1));
  assign hs        = (state_q == ST_SEND) && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      beat_q    <= 4'd0;
      pkt_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      beat_q    <= beat_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // A trigger seen in IDLE starts the packet directly, so pending is only ever left set by
  // triggers that arrive while a packet is in flight.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | req | beacon_expire;
    beat_d    = beat_q;
    pkt_cnt_d = pkt_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pending_d) begin
          state_d   = ST_SEND;
          pending_d = 1'b0;
          beat_d    = 4'd0;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (last_beat) begin
            state_d   = ST_IDLE;
            beat_d    = 4'd0;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_valid = 1'b0;
    m_last  = 1'b0;
    busy    = 1'b0;
    m_data  = '0;
    m_keep  = '0;
    if (state_q == ST_SEND) begin
      m_valid = 1'b1;
      busy    = 1'b1;
      m_last  = last_beat;
      for (int unsigned k = 0; k < Lanes; k++) begin
        if (32'(beat_q) * Lanes + k < C_PKT_BYTES) begin
          m_data[8*k +: 8] = pkt_byte(32'(beat_q) * Lanes + k, SOF_BYTE);
          m_keep[k]        = 1'b1;
        end
      end
    end
  end

  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_version_streamer.sv
// Directed bench for version_streamer: 8-bit and 32-bit framing, backpressure, reset abort,
// beacon timing. Expected bytes follow VERSION_STREAM_CKSUM_EN when it is defined.
module tb_version_streamer;

`ifdef VERSION_STREAM_CKSUM_EN
  localparam int NBytes = 14;
  localparam logic [31:0] ExpLastW32 = 32'h00002505;
  localparam logic [3:0]  ExpLastK32 = 4'h3;
`else
  localparam int NBytes = 13;
  localparam logic [31:0] ExpLastW32 = 32'h00000005;
  localparam logic [3:0]  ExpLastK32 = 4'h1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_a, valid_a, last_a, ready_a, busy_a;
  logic [7:0]  data_a;
  logic [0:0]  keep_a;
  logic [15:0] cnt_a;
  logic        req_b, valid_b, last_b, ready_b, busy_b;
  logic [31:0] data_b;
  logic [3:0]  keep_b;
  logic [15:0] cnt_b;
  logic        req_c, valid_c, last_c, ready_c, busy_c;
  logic [7:0]  data_c;
  logic [0:0]  keep_c;
  logic [15:0] cnt_c;

  version_streamer #(.DATA_W(8), .BEACON_CYCLES(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .m_data(data_a), .m_keep(keep_a),
    .m_valid(valid_a), .m_last(last_a), .m_ready(ready_a), .busy(busy_a), .pkt_cnt(cnt_a)
  );

  version_streamer #(.DATA_W(32), .BEACON_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .m_data(data_b), .m_keep(keep_b),
    .m_valid(valid_b), .m_last(last_b), .m_ready(ready_b), .busy(busy_b), .pkt_cnt(cnt_b)
  );

  version_streamer #(.DATA_W(8), .BEACON_CYCLES(100)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .m_data(data_c), .m_keep(keep_c),
    .m_valid(valid_c), .m_last(last_c), .m_ready(ready_c), .busy(busy_c), .pkt_cnt(cnt_c)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_bytes [0:13];
  logic [31:0] exp_w32 [0:3];
  logic [3:0]  exp_k32 [0:3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    int byte_idx, pkts, gap, rises, r0;
    logic gap_done, prev_valid, prev_hs, prev_last, hs, any_valid, found;
    logic [7:0] prev_data;
    int rise_at [0:3];

    exp_bytes = '{8'hA5, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h48, 8'h20, 8'h26, 8'h01, 8'h07,
                  8'h12, 8'h23, 8'h05, 8'h25};
    exp_w32 = '{32'h00000BA5, 32'h26204800, 32'h23120701, ExpLastW32};
    exp_k32 = '{4'hF, 4'hF, 4'hF, ExpLastK32};

    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_last", {31'd0, last_a}, 32'd0);
    check("rst_data", {24'd0, data_a}, 32'd0);
    check("rst_cnt", {16'd0, cnt_a}, 32'd0);
    check("rst_valid_b", {31'd0, valid_b}, 32'd0);
    rst_n = 1'b1;

    any_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_valid = any_valid | valid_a | valid_b;
    end
    check("idle_after_reset", {31'd0, any_valid}, 32'd0);

    // 8-bit packet, ready held high
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    check("a_first_valid", {31'd0, valid_a}, 32'd1);
    check("a_busy", {31'd0, busy_a}, 32'd1);
    check("a_keep", {31'd0, keep_a}, 32'd1);
    for (int i = 0; i < NBytes; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("a_byte%0d", i), {24'd0, data_a}, {24'd0, exp_bytes[i]});
      check($sformatf("a_last%0d", i), {31'd0, last_a}, {31'd0, i == NBytes - 1});
    end
    @(negedge clk);
    check("a_done_valid", {31'd0, valid_a}, 32'd0);
    check("a_done_busy", {31'd0, busy_a}, 32'd0);
    check("a_cnt1", {16'd0, cnt_a}, 32'd1);

    // 32-bit packet
    req_b = 1'b1;
    @(negedge clk);
    req_b = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      check($sformatf("b_valid%0d", j), {31'd0, valid_b}, 32'd1);
      check($sformatf("b_data%0d", j), data_b, exp_w32[j]);
      check($sformatf("b_keep%0d", j), {28'd0, keep_b}, {28'd0, exp_k32[j]});
      check($sformatf("b_last%0d", j), {31'd0, last_b}, {31'd0, j == 3});
    end
    @(negedge clk);
    check("b_done_valid", {31'd0, valid_b}, 32'd0);
    check("b_cnt1", {16'd0, cnt_b}, 32'd1);

    // Random backpressure with three extra reqs merged into one follow-up packet
    byte_idx = 0; pkts = 0; gap = 0; gap_done = 1'b0;
    prev_valid = 1'b0; prev_hs = 1'b0; prev_last = 1'b0; prev_data = 8'h00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (prev_valid && !prev_hs) begin
        check("stall_valid", {31'd0, valid_a}, 32'd1);
        check("stall_data", {24'd0, data_a}, {24'd0, prev_data});
        check("stall_last", {31'd0, last_a}, {31'd0, prev_last});
      end
      if (pkts == 1 && !gap_done) begin
        if (!valid_a) gap++;
        else begin
          check("idle_gap", gap, 32'd1);
          gap_done = 1'b1;
        end
      end
      req_a = (cyc == 0 || cyc == 3 || cyc == 6 || cyc == 9);
      ready_a = ($urandom_range(0, 1) == 1);
      hs = valid_a && ready_a;
      if (hs) begin
        check("bp_byte", {24'd0, data_a}, {24'd0, exp_bytes[byte_idx]});
        check("bp_last", {31'd0, last_a}, {31'd0, byte_idx == NBytes - 1});
        if (byte_idx == NBytes - 1) begin
          pkts++;
          byte_idx = 0;
        end else begin
          byte_idx++;
        end
      end
      prev_valid = valid_a; prev_hs = hs; prev_data = data_a; prev_last = last_a;
    end
    ready_a = 1'b1;
    req_a = 1'b0;
    check("bp_packets", pkts, 32'd2);
    check("bp_gap_seen", {31'd0, gap_done}, 32'd1);
    check("bp_cnt", {16'd0, cnt_a}, 32'd3);

    // Reset in the middle of a packet
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_byte5", {24'd0, data_a}, {24'd0, exp_bytes[5]});
    rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, valid_a}, 32'd0);
    check("abort_last", {31'd0, last_a}, 32'd0);
    check("abort_cnt", {16'd0, cnt_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // No output from A/B after release; beacon DUT fires 100 cycles after release
    any_valid = 1'b0; found = 1'b0; r0 = 0; prev_valid = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      any_valid = any_valid | valid_a | valid_b;
      if (valid_c && !prev_valid && !found) begin
        found = 1'b1;
        r0 = k;
      end
      prev_valid = valid_c;
    end
    check("post_reset_quiet", {31'd0, any_valid}, 32'd0);
    check("beacon_found", {31'd0, found}, 32'd1);
    check("beacon_first", r0, 32'd100);

    // Align to the first beacon packet start, then watch three periods with a coincident req
    prev_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (valid_c && !prev_valid) found = 1'b1;
      prev_valid = valid_c;
    end
    check("beacon_align", {31'd0, found}, 32'd1);
    rises = 0;
    for (int k = 1; k <= 320; k++) begin
      @(negedge clk);
      req_c = (k == 199);
      if (valid_c && !prev_valid) begin
        if (rises < 4) rise_at[rises] = k;
        rises++;
      end
      prev_valid = valid_c;
    end
    req_c = 1'b0;
    check("beacon_rises", rises, 32'd3);
    check("beacon_rise1", rise_at[0], 32'd100);
    check("beacon_rise2", rise_at[1], 32'd200);
    check("beacon_rise3", rise_at[2], 32'd300);
    check("beacon_cnt", {16'd0, cnt_c}, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
